mca_lut_multilane: RTL
======================

Name: mca_lut_multilane

Overview:
- Parametrised multi-cycle LUT accumulator for the CBADC digital estimator FIR path.
- Each of NUM_LUTS lookup tables holds 2**LUT_BITS signed coefficients. One LUT_BITS-wide slice of the control-bit vector selects one entry per table.
- The block sums all selected entries over ceil(NUM_LUTS/LANES) cycles, LANES tables per cycle, with a start/busy/res_valid handshake.
- Generalises the fixed 16-addition, 2-bit, single-lane accumulator. Lookup width, lane count and table count are free, and result width grows so the sum cannot overflow.

Parameters:
- WIDTH_COEFFICIENT, 32, signed coefficient width.
- NUM_LUTS, 16, number of tables (additions per result), >=1.
- LUT_BITS, 2, control bits per table; each table has 2**LUT_BITS entries; 1..4.
- LANES, 1, tables summed per cycle; 1..NUM_LUTS.
- NUM_GROUPS, ceil(NUM_LUTS/LANES), derived localparam: cycles per result.
- WIDTH_RES, WIDTH_COEFFICIENT+$clog2(NUM_LUTS)+1, derived localparam: result width.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global clock-enable; when low, every register holds.
- start  in  1  request a new accumulation; accepted only when busy=0 and enable=1.
- S_values  in  NUM_LUTS*LUT_BITS  control bits; table l index = S_values[l*LUT_BITS +: LUT_BITS]; sampled only on the accepting edge.
- lut_coeffs  in  NUM_LUTS*(2**LUT_BITS)*WIDTH_COEFFICIENT  flattened tables; entry e of table l at [(l*2**LUT_BITS+e)*WIDTH_COEFFICIENT +: WIDTH_COEFFICIENT]; must be stable from start until res_valid.
- busy  out  1  high while accumulating.
- res_valid  out  1  one-enabled-cycle pulse: res updated.
- res  out  WIDTH_RES  signed sum of selected entries; holds until the next result.

Behaviour:
- Reset (reset=1 at an edge, with priority over enable) sets:
  - state=IDLE, group counter=0, accumulator=0;
  - res=0, res_valid=0, busy=0;
  - latched S register=0.
- Reset applies in any state; an in-flight accumulation is discarded and no res_valid is produced.
- States and transitions:
  - IDLE: on an edge with enable & start, latch S_values into the internal register, clear the accumulator, set counter=0, go to ADDING. Otherwise stay in IDLE.
  - ADDING, each enabled edge: the accumulator takes accumulator + sum of LANES lookups for tables counter*LANES .. counter*LANES+LANES-1. Table indices >= NUM_LUTS contribute 0 (partial last group).
  - ADDING, when counter == NUM_GROUPS-1: res takes accumulator + last group sum, res_valid is set to 1, counter resets to 0, go to IDLE. Otherwise counter increments.
- busy = (state==ADDING), combinational from state.
- res_valid:
  - Set only on the final ADDING edge.
  - Cleared on the next enabled edge.
  - Holds while enable=0.
- Latency: start accepted at enabled edge N. res and res_valid appear after enabled edge N+NUM_GROUPS. Stalled (enable=0) cycles add 1 each.
- Back-to-back operation:
  - start may be asserted in the cycle res_valid is high, since state is IDLE. It is accepted there.
  - Throughput is one result per NUM_GROUPS+1 enabled cycles.
- start while busy is ignored and not queued. S_values changes after acceptance have no effect.
- Arithmetic:
  - Coefficients are sign-extended to WIDTH_RES before addition; the lane sum and the accumulator are WIDTH_RES wide.
  - There is no wrap and no saturation; the width guarantees an exact result.
- NUM_GROUPS==1: the accepting edge leads to a single ADDING edge, which produces the result.
- LANES==NUM_LUTS is legal, as is NUM_LUTS not divisible by LANES.

Test Plan:
1. Configuration for T1–T5: NUM_LUTS=5, LANES=2, LUT_BITS=2, WIDTH_COEFFICIENT=8, so NUM_GROUPS=3 and WIDTH_RES=12.
   - Coefficients: entry e of table l = 10*l+e. All indices =3, start at enabled edge 0.
   - Required: busy high for 3 cycles, res_valid after edge 3, res=115.
2. Same configuration, all coefficients -128, arbitrary indices -> res=-640, no overflow.
3. T1 stimulus with enable=0 for 2 cycles mid-ADDING:
   - Required: res_valid delayed to after edge 5, res=115.
   - res_valid stays high across a later enable=0 cycle.
4. Handshake robustness:
   - Start T1; toggle S_values to all-zero indices and pulse start at edge 1 -> res=115, exactly one res_valid.
   - Then start with all indices 0 in the res_valid cycle -> res=100 three edges later.
5. Reset mid-operation: assert reset at edge 2 of T1 -> busy=0, res=0, no res_valid. A fresh start afterwards gives res=115.
6. Default parameters (16 tables, 2 bits, 1 lane, 32-bit), random indices and coefficients against a reference-model sum:
   - Required: latency 16 and bit-exact results, including sums beyond the 32-bit range.

Source files
------------

// File: rtl/mca_lut_multilane_if.sv
// Bus bundle for the multi-cycle LUT accumulator.
// Ports carried:
//   enable     - global clock-enable for the accumulator
//   start      - request a new accumulation
//   S_values   - NUM_LUTS x LUT_BITS control bits, one index per table
//   lut_coeffs - flattened coefficient tables, NUM_LUTS x 2**LUT_BITS entries
//   busy       - accumulation in progress
//   res_valid  - result register updated on the last enabled edge
//   res        - signed result, wide enough that the sum never overflows
// The master drives the request side; the accumulator is the slave.
interface mca_lut_multilane_if #(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int NUM_LUTS          = 16,
    parameter int LUT_BITS          = 2
);
    localparam int WIDTH_RES = WIDTH_COEFFICIENT + $clog2(NUM_LUTS) + 1;

    logic                                                 enable;
    logic                                                 start;
    logic [NUM_LUTS*LUT_BITS-1:0]                         S_values;
    logic [NUM_LUTS*(2**LUT_BITS)*WIDTH_COEFFICIENT-1:0]  lut_coeffs;
    logic                                                 busy;
    logic                                                 res_valid;
    logic signed [WIDTH_RES-1:0]                          res;

    modport master (
        output enable, start, S_values, lut_coeffs,
        input  busy, res_valid, res
    );

    modport slave (
        input  enable, start, S_values, lut_coeffs,
        output busy, res_valid, res
    );
endinterface

// File: rtl/mca_lut_multilane.sv
// Multi-cycle LUT accumulator for the CBADC digital estimator FIR path.
// Each of NUM_LUTS tables holds 2**LUT_BITS signed coefficients; one
// LUT_BITS-wide slice of the latched control vector selects one entry per
// table. LANES tables are summed per cycle, so a result takes NUM_GROUPS
// enabled cycles after the accepting edge.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; wins over enable
//   bus   - slave side of mca_lut_multilane_if (enable, start, S_values,
//           lut_coeffs in; busy, res_valid, res out)
module mca_lut_multilane #(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int NUM_LUTS          = 16,
    parameter int LUT_BITS          = 2,
    parameter int LANES             = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mca_lut_multilane_if.slave   bus
);
    localparam int NUM_GROUPS = (NUM_LUTS + LANES - 1) / LANES;
    localparam int WIDTH_RES  = WIDTH_COEFFICIENT + $clog2(NUM_LUTS) + 1;
    localparam int ENTRIES    = 2 ** LUT_BITS;
    localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int S_W        = NUM_LUTS * LUT_BITS;
    localparam int C_W        = NUM_LUTS * ENTRIES * WIDTH_COEFFICIENT;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ADDING = 1'b1
    } state_t;

    state_t                      state_r, state_nxt_s;
    logic [CNT_W-1:0]            cnt_r, cnt_nxt_s;
    logic signed [WIDTH_RES-1:0] acc_r, acc_nxt_s;
    logic signed [WIDTH_RES-1:0] res_r, res_nxt_s;
    logic                        res_valid_r, res_valid_nxt_s;
    logic [S_W-1:0]              s_r, s_nxt_s;
    logic signed [WIDTH_RES-1:0] lane_sum_s;

    // Selected entry of one table, sign-extended to the result width.
    // Tables past the end (partial last group) contribute zero.
    function automatic logic signed [WIDTH_RES-1:0] lookup(
        input int             tbl,
        input logic [S_W-1:0] sel,
        input logic [C_W-1:0] coeffs
    );
        logic [LUT_BITS-1:0]          idx;
        logic [WIDTH_COEFFICIENT-1:0] coeff;
        if (tbl < NUM_LUTS) begin
            idx   = sel[tbl*LUT_BITS +: LUT_BITS];
            coeff = coeffs[(tbl*ENTRIES + int'(idx))*WIDTH_COEFFICIENT +: WIDTH_COEFFICIENT];
            return {{(WIDTH_RES-WIDTH_COEFFICIENT){coeff[WIDTH_COEFFICIENT-1]}}, coeff};
        end else begin
            return '0;
        end
    endfunction

    // Sum of the LANES lookups belonging to the current group.
    always_comb begin
        lane_sum_s = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum_s = lane_sum_s + lookup(int'(cnt_r) * LANES + k, s_r, bus.lut_coeffs);
        end
    end

    // Next-state and next-register values; res_valid defaults low so it
    // drops on the enabled edge after it was raised.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        acc_nxt_s       = acc_r;
        res_nxt_s       = res_r;
        res_valid_nxt_s = 1'b0;
        s_nxt_s         = s_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    s_nxt_s     = bus.S_values;
                    acc_nxt_s   = '0;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ADDING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDING: begin
                if (cnt_r == LAST_GROUP) begin
                    res_nxt_s       = acc_r + lane_sum_s;
                    res_valid_nxt_s = 1'b1;
                    cnt_nxt_s       = '0;
                    state_nxt_s     = IDLE;
                end else begin
                    acc_nxt_s = acc_r + lane_sum_s;
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State and datapath registers; reset has priority, enable low holds all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            acc_r       <= '0;
            res_r       <= '0;
            res_valid_r <= 1'b0;
            s_r         <= '0;
        end else if (bus.enable) begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            acc_r       <= acc_nxt_s;
            res_r       <= res_nxt_s;
            res_valid_r <= res_valid_nxt_s;
            s_r         <= s_nxt_s;
        end else begin
            state_r     <= state_r;
            cnt_r       <= cnt_r;
            acc_r       <= acc_r;
            res_r       <= res_r;
            res_valid_r <= res_valid_r;
            s_r         <= s_r;
        end
    end

    assign bus.busy      = (state_r == ADDING);
    assign bus.res_valid = res_valid_r;
    assign bus.res       = res_r;
endmodule
